rr_packet_switch_allocator: RTL



---
 rtl/rr_packet_switch_allocator.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rr_packet_switch_allocator.sv
// Per-output-port switch allocator: round-robin wormhole arbitration,
// credit-gated flit forwarding and a watchdog that frees stalled grants.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req            per-input request (flit present for this output)
//   flit_id        3 bits per input: 001 head, 010 body, 100 tail, 101 single
//   credit_in      one-cycle pulse, downstream freed one slot
//   timeout_limit  watchdog limit in stall cycles, 0 disables it
//   grant          registered one-hot grant, zero when idle
//   xbar_sel       binary index of the granted port, 3'b111 when idle
//   fwd_valid      holder's flit is forwarded this cycle
//   credit_cnt     available downstream credits
//   busy           a packet currently holds the output
//   timeout_err    one-cycle pulse when the watchdog drops a grant
module rr_packet_switch_allocator #(
    parameter int N_PORTS = 5,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     req,
    input  logic [3*N_PORTS-1:0]   flit_id,
    input  logic                   credit_in,
    input  logic [11:0]            timeout_limit,
    output logic [N_PORTS-1:0]     grant,
    output logic [2:0]             xbar_sel,
    output logic                   fwd_valid,
    output logic [CNT_W-1:0]       credit_cnt,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [2:0]       LAST_PORT = 3'(N_PORTS - 1);
    localparam logic [CNT_W-1:0] CRED_MAX  = CNT_W'(CREDITS);

    state_t           state;
    logic [2:0]       holder;
    logic [2:0]       ptr;
    logic [11:0]      wd_cnt;
    logic [CNT_W-1:0] cnt;

    logic [N_PORTS-1:0] eligible;
    logic               found;
    logic [2:0]         pick;
    logic               req_h;
    logic [2:0]         flit_h;
    logic               is_tail;
    logic [2:0]         holder_next;
    logic               wd_fire;

    // A port may only win arbitration with a packet-opening flit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = req[i] &&
                          (flit_id[3*i +: 3] == 3'b001 ||
                           flit_id[3*i +: 3] == 3'b101);
        end
    end

    // Scan ptr, ptr+1, ... wrapping; the first eligible port wins.
    always_comb begin
        logic [3:0] j;
        found = 1'b0;
        pick  = '0;
        j     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            j = {1'b0, ptr} + 4'(k);
            if (j >= 4'(N_PORTS)) begin
                j = j - 4'(N_PORTS);
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (!found && j == 4'(i) && eligible[i]) begin
                    found = 1'b1;
                    pick  = 3'(i);
                end
            end
        end
    end

    // Holder's request and flit type, muxed with constant indices.
    always_comb begin
        req_h  = 1'b0;
        flit_h = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (holder == 3'(i)) begin
                req_h  = req[i];
                flit_h = flit_id[3*i +: 3];
            end
        end
    end

    assign is_tail     = (flit_h == 3'b100) || (flit_h == 3'b101);
    assign holder_next = (holder == LAST_PORT) ? 3'd0 : holder + 3'd1;

    assign fwd_valid = (state == LOCKED) && req_h && (cnt != '0);

    // Fires on the stall cycle that brings the count up to the limit;
    // >= lets a lowered limit take effect at once mid-packet.
    assign wd_fire = (timeout_limit != 12'd0) &&
                     (({1'b0, wd_cnt} + 13'd1) >= {1'b0, timeout_limit});

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            holder      <= '0;
            ptr         <= '0;
            wd_cnt      <= '0;
            grant       <= '0;
            xbar_sel    <= 3'b111;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (found) begin
                        state    <= LOCKED;
                        holder   <= pick;
                        grant    <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick;
                        xbar_sel <= pick;
                        busy     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (fwd_valid) begin
                        wd_cnt <= '0;
                        if (is_tail) begin
                            state    <= IDLE;
                            grant    <= '0;
                            xbar_sel <= 3'b111;
                            busy     <= 1'b0;
                            ptr      <= holder_next;
                        end
                    end else if (wd_fire) begin
                        state       <= IDLE;
                        grant       <= '0;
                        xbar_sel    <= 3'b111;
                        busy        <= 1'b0;
                        ptr         <= holder_next;
                        wd_cnt      <= '0;
                        timeout_err <= 1'b1;
                    end else if (wd_cnt != 12'hfff) begin
                        wd_cnt <= wd_cnt + 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A return and a send in the same cycle cancel out; returns beyond
    // the buffer depth are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CRED_MAX;
        end else if (fwd_valid && !credit_in) begin
            cnt <= cnt - 1'b1;
        end else if (credit_in && !fwd_valid && cnt != CRED_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign credit_cnt = cnt;

endmodule
